// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// FSM state encoding and the hard-wired zero register index.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Read-after-write detection between the ID sources and the EX/MEM destinations.
// No forwarding exists; WB is safe because the register file writes before it reads.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] ex_regw_addr,
    input  logic [4:0] mem_regw_addr,
    input  logic       ex_wb_wen,
    input  logic       mem_wb_wen,
    output logic       raw_hazard
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit = id_use_rs && (id_rs != REG_ZERO) &&
                 ((ex_wb_wen  && (id_rs == ex_regw_addr)) ||
                  (mem_wb_wen && (id_rs == mem_regw_addr)));
        rt_hit = id_use_rt && (id_rt != REG_ZERO) &&
                 ((ex_wb_wen  && (id_rt == ex_regw_addr)) ||
                  (mem_wb_wen && (id_rt == mem_regw_addr)));
        raw_hazard = rs_hit || rt_hit;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline advance/flush/stall controller with memory-wait and debug-halt FSM.
//   state    | meaning
//   RUN      | normal issue; branch flush or RAW stall decided each cycle
//   MEM_WAIT | data memory outstanding; whole pipe frozen until mem_ack
//   HALT     | debug freeze; dbg_step releases exactly one cycle
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  ex_regw_addr,
    input  logic [4:0]  mem_regw_addr,
    input  logic        ex_wb_wen,
    input  logic        mem_wb_wen,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        dbg_halt,
    input  logic        dbg_step,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [1:0]  state_o
);

    state_e      state_q, state_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        raw_hazard;
    logic        run_rules;
    logic        stall_inc;
    logic        flush_inc;

    hazard_detect u_hazard (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .ex_regw_addr  (ex_regw_addr),
        .mem_regw_addr (mem_regw_addr),
        .ex_wb_wen     (ex_wb_wen),
        .mem_wb_wen    (mem_wb_wen),
        .raw_hazard    (raw_hazard)
    );

    always_comb begin
        state_d     = state_q;
        run_rules   = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ack) begin
                    state_d   = ST_MEM_WAIT;
                    stall_inc = 1'b1;
                end else begin
                    run_rules = 1'b1;
                    if (dbg_halt) state_d = ST_HALT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    run_rules = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            ST_HALT: begin
                run_rules = dbg_step;
                if (!dbg_halt) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        if (run_rules) begin
            if (ex_branch_taken) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                flush_inc   = 1'b1;
            end else if (raw_hazard) begin
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                idex_bubble = 1'b1;
                // Halt is observational: a stepped stall is not counted.
                stall_inc   = (state_q != ST_HALT);
            end else begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
            end
        end

        stall_cnt_d = stall_cnt_q + {31'd0, stall_inc};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_inc};

        // Outputs are combinational, so reset must mask them directly.
        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the stall/flush rules.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_regw_addr, mem_regw_addr;
    logic        id_use_rs, id_use_rt, ex_wb_wen, mem_wb_wen;
    logic        ex_branch_taken, mem_req, mem_ack, dbg_halt, dbg_step;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_bubble;
    logic [31:0] stall_cnt, flush_cnt;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_regw_addr(ex_regw_addr), .mem_regw_addr(mem_regw_addr),
        .ex_wb_wen(ex_wb_wen), .mem_wb_wen(mem_wb_wen),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .dbg_halt(dbg_halt), .dbg_step(dbg_step),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_o(state_o)
    );

    wire [4:0] en_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_regw_addr = 0; mem_regw_addr = 0; ex_wb_wen = 0; mem_wb_wen = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ack = 0; dbg_halt = 0; dbg_step = 0;
    endtask

    // Starts and ends one time unit after a rising edge.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        #7 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (en_vec !== 5'b0 || ifid_flush !== 1'b0 || idex_bubble !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs en=%b flush=%b bubble=%b required en=00000 flush=0 bubble=0",
                     en_vec, ifid_flush, idex_bubble);
        end
        checks++;
        if (state_o !== 2'd0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state state=%0d stall=%0d flush=%0d required 0 0 0",
                     state_o, stall_cnt, flush_cnt);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_raw_stall();
        do_reset();
        ex_regw_addr = 5; ex_wb_wen = 1; id_rs = 5; id_use_rs = 1;
        #4;
        checks++;
        if (en_vec !== 5'b00011 || idex_bubble !== 1'b1 || ifid_flush !== 1'b0) begin
            errors++;
            $display("FAIL raw_stall en=%b bubble=%b flush=%b required en=00011 bubble=1 flush=0",
                     en_vec, idex_bubble, ifid_flush);
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL raw_stall_cnt got %0d required 1", stall_cnt);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        id_rs = 0; id_use_rs = 1; ex_regw_addr = 0; ex_wb_wen = 1;
        id_rt = 0; id_use_rt = 1; mem_regw_addr = 0; mem_wb_wen = 1;
        #4;
        checks++;
        if (en_vec !== 5'b11111 || idex_bubble !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg en=%b bubble=%b required en=11111 bubble=0", en_vec, idex_bubble);
        end
        @(posedge clk); #1;
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL zero_reg_cnt got %0d required 0", stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++;
            if (en_vec !== 5'b0) begin
                errors++;
                $display("FAIL mem_wait_en cycle %0d en=%b required 00000", i, en_vec);
            end
            @(posedge clk); #1;
            checks++;
            if (state_o !== 2'd1) begin
                errors++;
                $display("FAIL mem_wait_state cycle %0d got %0d required 1", i, state_o);
            end
        end
        mem_ack = 1;
        #4;
        checks++;
        if (en_vec !== 5'b11111) begin
            errors++;
            $display("FAIL mem_ack_en en=%b required 11111", en_vec);
        end
        @(posedge clk); #1;
        checks++;
        if (state_o !== 2'd0 || stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL mem_ack_exit state=%0d stall=%0d required state=0 stall=3", state_o, stall_cnt);
        end
    endtask

    task automatic test_branch_hazard();
        do_reset();
        ex_regw_addr = 7; ex_wb_wen = 1; id_rt = 7; id_use_rt = 1; ex_branch_taken = 1;
        #4;
        checks++;
        if (en_vec !== 5'b11111 || ifid_flush !== 1'b1 || idex_bubble !== 1'b1) begin
            errors++;
            $display("FAIL branch_hazard en=%b flush=%b bubble=%b required en=11111 flush=1 bubble=1",
                     en_vec, ifid_flush, idex_bubble);
        end
        @(posedge clk); #1;
        checks++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL branch_hazard_cnt flush=%0d stall=%0d required flush=1 stall=0",
                     flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_halt_step();
        int advanced = 0;
        do_reset();
        dbg_halt = 1;
        #4;
        checks++;
        if (en_vec !== 5'b11111) begin
            errors++;
            $display("FAIL halt_entry_en en=%b required 11111", en_vec);
        end
        @(posedge clk); #1;
        checks++;
        if (state_o !== 2'd2) begin
            errors++;
            $display("FAIL halt_state got %0d required 2", state_o);
        end
        for (int i = 0; i < 10; i++) begin
            dbg_step = (i == 2 || i == 6);
            #4;
            if (en_vec === 5'b11111) advanced++;
            @(posedge clk); #1;
        end
        dbg_step = 0;
        checks++;
        if (advanced != 2 || state_o !== 2'd2 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL halt_step advanced=%0d state=%0d stall=%0d required 2 2 0",
                     advanced, state_o, stall_cnt);
        end
        dbg_halt = 0;
        #4;
        checks++;
        if (en_vec !== 5'b0) begin
            errors++;
            $display("FAIL halt_release_en en=%b required 00000", en_vec);
        end
        @(posedge clk); #1;
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL halt_release_state got %0d required 0", state_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_req = 0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (state_o !== 2'd0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || en_vec !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_wait state=%0d stall=%0d flush=%0d en=%b required 0 0 0 00000",
                     state_o, stall_cnt, flush_cnt, en_vec);
        end
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (en_vec !== 5'b11111) begin
            errors++;
            $display("FAIL reset_release_en en=%b required 11111", en_vec);
        end
        @(posedge clk); #1;
        checks++;
        if (state_o !== 2'd0 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_release_state state=%0d stall=%0d required 0 0", state_o, stall_cnt);
        end
    endtask

    // Reference model: each cycle is classified as frozen, flushed, stalled or advancing.
    typedef enum int {M_FROZEN, M_BRANCH, M_STALL, M_ADVANCE} mode_e;

    function automatic bit src_conflict(bit used, logic [4:0] r);
        if (!used || r == 0) return 0;
        return (ex_wb_wen && r == ex_regw_addr) || (mem_wb_wen && r == mem_regw_addr);
    endfunction

    task automatic test_random();
        int    ms = 0;
        int    exp_stall = 0;
        int    exp_flush = 0;
        mode_e mode;
        bit    frozen, hazard;
        logic [4:0] exp_en;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_regw_addr  = 5'($urandom_range(0, 3));
            mem_regw_addr = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            ex_wb_wen = 1'($urandom); mem_wb_wen = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            mem_req  = (ms != 2) && ($urandom_range(0, 3) == 0);
            mem_ack  = 1'($urandom);
            dbg_halt = ($urandom_range(0, 7) == 0) || (ms == 2 && $urandom_range(0, 3) != 0);
            dbg_step = ($urandom_range(0, 2) == 0);

            hazard = src_conflict(id_use_rs, id_rs) || src_conflict(id_use_rt, id_rt);
            frozen = (ms == 0 && mem_req && !mem_ack) || (ms == 1 && !mem_ack) || (ms == 2 && !dbg_step);
            if (frozen)               mode = M_FROZEN;
            else if (ex_branch_taken) mode = M_BRANCH;
            else if (hazard)          mode = M_STALL;
            else                      mode = M_ADVANCE;
            case (mode)
                M_FROZEN: exp_en = 5'b00000;
                M_STALL:  exp_en = 5'b00011;
                default:  exp_en = 5'b11111;
            endcase

            #4;
            checks++;
            if (en_vec !== exp_en || ifid_flush !== (mode == M_BRANCH) ||
                idex_bubble !== (mode == M_BRANCH || mode == M_STALL) || state_o !== 2'(ms)) begin
                errors++;
                $display("FAIL random_comb cyc %0d en=%b flush=%b bubble=%b state=%0d required en=%b flush=%b bubble=%b state=%0d",
                         cyc, en_vec, ifid_flush, idex_bubble, state_o, exp_en,
                         mode == M_BRANCH, mode == M_BRANCH || mode == M_STALL, ms);
            end

            if (ms != 2 && (frozen || mode == M_STALL)) exp_stall++;
            if (mode == M_BRANCH) exp_flush++;
            case (ms)
                0:       ms = (mem_req && !mem_ack) ? 1 : (dbg_halt ? 2 : 0);
                1:       ms = mem_ack ? 0 : 1;
                default: ms = dbg_halt ? 2 : 0;
            endcase

            @(posedge clk); #1;
            checks++;
            if (stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush) || state_o !== 2'(ms)) begin
                errors++;
                $display("FAIL random_regs cyc %0d stall=%0d flush=%0d state=%0d required %0d %0d %0d",
                         cyc, stall_cnt, flush_cnt, state_o, exp_stall, exp_flush, ms);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_raw_stall();
        test_zero_reg();
        test_mem_wait();
        test_branch_hazard();
        test_halt_step();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have ports id_use_rs and id_use_rt, input, 1 bit each: the ID instruction reads rs / rt.
REQ-005 SHALL have ports ex_regw_addr and mem_regw_addr, input, 5 bits each: destination registers in EX and MEM.
REQ-006 SHALL have ports ex_wb_wen and mem_wb_wen, input, 1 bit each: valid-qualified write enables of EX and MEM.
REQ-007 SHALL have port ex_branch_taken, input, 1 bit: a branch or jump is resolved taken in EX.
REQ-008 SHALL have ports mem_req and mem_ack, input, 1 bit each: data-memory access request and completion.
REQ-009 SHALL have ports dbg_halt and dbg_step, input, 1 bit each: debug freeze and single-step pulse.
REQ-010 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en and memwb_en, 1 bit each: per-stage advance enables; memwb_en drives the MEM/WB en, so 0 inserts a WB bubble.
REQ-011 SHALL have outputs ifid_flush and idex_bubble, 1 bit each: load a NOP / invalid entry into IF/ID or ID/EX.
REQ-012 SHALL have outputs stall_cnt and flush_cnt, 32 bits each: performance counters.
REQ-013 SHALL have output state_o, 2 bits: current FSM state.

Function
REQ-014 FSM states SHALL be RUN=0, MEM_WAIT=1, HALT=2; encoding 3 is illegal and SHALL recover to RUN on the next edge.
REQ-015 raw_hazard SHALL be 1 when id_use_rs is set, id_rs != 0 and id_rs matches ex_regw_addr (with ex_wb_wen) or mem_regw_addr (with mem_wb_wen); the same term applies to rt. There is no forwarding, and the register file write-before-read makes WB non-hazardous.
REQ-016 In RUN with mem_req=1 and mem_ack=0, all five enables SHALL be 0 in the same cycle, and the next state SHALL be MEM_WAIT.
REQ-017 In MEM_WAIT, all enables SHALL stay 0 until mem_ack=1. In the mem_ack cycle, the enables SHALL follow RUN rules, and the next state SHALL be RUN.
REQ-018 In RUN, with no memory wait and dbg_halt=1, the next state SHALL be HALT. The current cycle still advances.
REQ-019 In HALT, all enables SHALL be 0 except in a cycle with dbg_step=1, which applies RUN rules for exactly that cycle. dbg_halt=0 SHALL return the FSM to RUN.
REQ-020 In RUN with ex_branch_taken=1, all enables SHALL be 1, and ifid_flush and idex_bubble SHALL both be 1; flush_cnt increments by 1.
REQ-021 In RUN with raw_hazard=1 and no branch, pc_en, ifid_en and idex_en SHALL be 0; exmem_en, memwb_en and idex_bubble SHALL be 1; stall_cnt increments by 1.
REQ-022 Priority SHALL be: memory wait, then halt/step, then branch, then raw_hazard. A branch coincident with a hazard flushes and does not stall.
REQ-023 In RUN with no event, all enables SHALL be 1, and ifid_flush and idex_bubble SHALL be 0.
REQ-024 stall_cnt SHALL also increment in every cycle spent in MEM_WAIT with mem_ack=0. It SHALL NOT increment in HALT.
REQ-025 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 All outputs SHALL be combinational from the registered state and the current inputs, except the counters, which are registered. The decision latency is 0 cycles.

Reset
REQ-027 While rst=0, the state SHALL be RUN, both counters 0, and all enables, ifid_flush and idex_bubble 0, regardless of clk.
REQ-028 Reset asserted mid-MEM_WAIT or mid-HALT SHALL abandon the wait immediately; the first edge after deassertion operates from RUN.

Structure
REQ-029 A shared package pipe_ctrl_pkg SHALL hold the state encoding constants and REG_ZERO=5'd0.
REQ-030 Hazard comparison SHALL live in one combinational sub-module, hazard_detect (inputs: REQ-003 to REQ-006; output: raw_hazard).

Verification
REQ-031 Scenario: ex_regw_addr=5, ex_wb_wen=1, id_rs=5, id_use_rs=1 -> pc_en=ifid_en=idex_en=0, idex_bubble=1, stall_cnt=1 after one edge.
REQ-032 Scenario: id_rs=0 matching ex_regw_addr=0 with ex_wb_wen=1 -> no stall, all enables 1.
REQ-033 Scenario: mem_req=1 held, mem_ack=0 for 3 cycles then 1 -> enables 0 for 3 cycles, state_o=1, stall_cnt=3, return to RUN.
REQ-034 Scenario: ex_branch_taken=1 concurrent with raw_hazard -> ifid_flush=idex_bubble=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
REQ-035 Scenario: dbg_halt=1, then two dbg_step pulses 4 cycles apart -> exactly 2 cycles with enables 1 in HALT.
REQ-036 Scenario: rst driven low mid-MEM_WAIT between clock edges -> state_o=0, counters 0 and enables 0 immediately.
